ip_sequencer: RTL

Parametrised instruction-pointer sequencer, the next generation of the core's fetch-address unit. Each cycle it selects the next instruction-memory address:
- hold or sequential increment
- absolute or PC-relative jump
- conditional branch on equal / not-equal compare
- call / return through an internal return-address stack

It sits between the decoder (op, target, compare operands) and instruction memory (address).

---
 rtl/ip_sequencer_pkg.sv | 15 +
 rtl/ip_return_stack.sv | 60 ++++++
 rtl/ip_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ip_sequencer_pkg.sv
// Shared definitions for the instruction-pointer sequencer: opcode width and encodings.
package ip_sequencer_pkg;

    localparam int unsigned OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_NEXT     = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_HOLD     = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_JUMP     = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_BR_EQ    = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_BR_NE    = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_CALL     = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_RET      = 3'd6;
    localparam logic [OP_WIDTH-1:0] OP_RESET_IP = 3'd7;

endpackage : ip_sequencer_pkg

// File: rtl/ip_return_stack.sv
// LIFO return-address stack; only the occupancy count is reset, entries keep stale data.
module ip_return_stack #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned CNT_WIDTH = $clog2(STACK_DEPTH + 1);

    logic [CNT_WIDTH-1:0]  count;
    logic [ADDR_WIDTH-1:0] entries [STACK_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(STACK_DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CNT_WIDTH'(1);
        end else if (do_pop) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    // Storage is write-only on push; no reset so it maps onto plain flops/latch-free regs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (do_push && (count == CNT_WIDTH'(i))) begin
                entries[i] <= push_data;
            end
        end
    end

    // Top of stack is entry[count-1]; zero when empty.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (count == CNT_WIDTH'(i + 1)) begin
                top_data = entries[i];
            end
        end
    end

endmodule : ip_return_stack

// File: rtl/ip_sequencer.sv
// Fetch-address sequencer: selects next instruction address from op, target, compare and return stack.
module ip_sequencer
    import ip_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic                  i_relative,
    input  logic [ADDR_WIDTH-1:0] i_target,
    input  logic [DATA_WIDTH-1:0] i_object,
    input  logic [DATA_WIDTH-1:0] i_condition,
    output logic [ADDR_WIDTH-1:0] o_memory_address,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_stack_empty,
    output logic                  o_stack_full,
    output logic                  o_fault
);

    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);

    logic [ADDR_WIDTH-1:0] reg_pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  operands_equal;
    logic                  push;
    logic                  pop;
    logic                  clear;
    logic                  set_fault;
    logic                  fault;

    assign pc_inc         = reg_pc + ADDR_WIDTH'(1);
    assign tgt            = i_relative ? (reg_pc + i_target) : i_target;
    assign operands_equal = (i_object == i_condition);

    // Address mux and stack/fault control, decoded from the opcode.
    always_comb begin
        next_addr = pc_inc;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        set_fault = 1'b0;
        case (i_op)
            OP_NEXT:  next_addr = pc_inc;
            OP_HOLD:  next_addr = reg_pc;
            OP_JUMP:  next_addr = tgt;
            OP_BR_EQ: next_addr = operands_equal ? tgt : pc_inc;
            OP_BR_NE: next_addr = operands_equal ? pc_inc : tgt;
            OP_CALL: begin
                if (o_stack_full) begin
                    next_addr = reg_pc;
                    set_fault = 1'b1;
                end else begin
                    next_addr = tgt;
                    push      = 1'b1;
                end
            end
            OP_RET: begin
                if (o_stack_empty) begin
                    next_addr = reg_pc;
                    set_fault = 1'b1;
                end else begin
                    next_addr = top_data;
                    pop       = 1'b1;
                end
            end
            OP_RESET_IP: begin
                next_addr = RST_PC;
                clear     = 1'b1;
            end
        endcase
    end

    // Reset overrides the fetch address immediately, not just at the next edge.
    assign o_memory_address = rst_n ? next_addr : RST_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_pc <= RST_PC;
            fault  <= 1'b0;
        end else begin
            reg_pc <= o_memory_address;
            if (clear) begin
                fault <= 1'b0;
            end else if (set_fault) begin
                fault <= 1'b1;
            end
        end
    end

    assign o_pc    = reg_pc;
    assign o_fault = fault;

    ip_return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (pc_inc),
        .top_data  (top_data),
        .empty     (o_stack_empty),
        .full      (o_stack_full)
    );

endmodule : ip_sequencer
